// File: rtl/peripheral_mpi_noc_arbiter.sv
// ---------------------------------------------------------------------------
// peripheral_mpi_noc_arbiter
//
// Packet-granular round-robin arbiter. Merges the outgoing NoC streams of N
// MPI endpoints onto one NoC output link. Once a requester is granted, the
// grant is held from its first flit through its last flit, so packets from
// different endpoints never interleave on the output.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   in_flit    requester flits, requester i at [i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH]
//   in_last    last-flit marker per requester
//   in_valid   flit valid per requester
//   in_ready   flit accepted per requester
//   out_flit   merged flit towards the NoC
//   out_last   last flit of the current packet
//   out_valid  merged flit valid
//   out_ready  NoC accepts the flit
//   grant      one-hot current owner, zero while idle
//   busy       high while a packet is locked (also the FSM state: 1 = LOCKED)
//
// Handshake: a flit moves on a rising edge where valid and ready are both
// high. Valid never depends on ready; ready (in_ready) is a pure function of
// the grant and out_ready. A source holds flit/last stable while valid is
// high and ready is low.
// ---------------------------------------------------------------------------
module peripheral_mpi_noc_arbiter #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int N              = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N*NOC_FLIT_WIDTH-1:0] in_flit,
    input  logic [N-1:0]                in_last,
    input  logic [N-1:0]                in_valid,
    output logic [N-1:0]                in_ready,
    output logic [NOC_FLIT_WIDTH-1:0]   out_flit,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                grant,
    output logic                        busy
);

    localparam int OW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]                state;
    logic [OW-1:0]             owner;
    logic [OW-1:0]             rr_ptr;
    logic [OW-1:0]             pick;
    logic [OW-1:0]             cand;
    logic                      pick_found;
    logic                      locked;
    logic                      xfer;
    logic [NOC_FLIT_WIDTH-1:0] flit_arr [N];

    assign locked = (state == LOCKED);

    // Unpack the flat flit bus so the owner can select its lane directly.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            flit_arr[i] = in_flit[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
        end
    end

    // Search starts just after the last winner, so the requester that most
    // recently finished a packet is considered last.
    always_comb begin
        pick       = '0;
        cand       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = OW'((int'(rr_ptr) + k) % N);
            if (!pick_found && in_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Datapath is purely combinational from the owner; forced to zero in IDLE.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            grant[i] = locked && (owner == OW'(i));
        end
    end

    assign out_flit  = locked ? flit_arr[owner] : '0;
    assign out_last  = locked & in_last[owner];
    assign out_valid = locked & in_valid[owner];
    assign in_ready  = grant & {N{out_ready}};
    assign busy      = locked;
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= OW'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    // Arbitration cycle: no flit moves while the owner is chosen.
                    if (pick_found) begin
                        owner <= pick;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer && out_last) begin
                        state  <= IDLE;
                        rr_ptr <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/peripheral_mpi_noc_arbiter.md
Name: peripheral_mpi_noc_arbiter

Overview:
Packet-granular round-robin arbiter that merges the outgoing NoC streams of N MPI endpoints (peripheral_mpi_ahb4 instances) onto a single NoC output link. A grant is locked from the first flit of a packet to its last flit, so packets never interleave. It sits between the endpoints' noc_out ports and the router local input port.

Parameters:
NOC_FLIT_WIDTH, 32, flit width in bits
N, 4, number of requesting endpoints (N >= 1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
in_flit  input  N*NOC_FLIT_WIDTH  requester flits; requester i at [i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH]
in_last  input  N  last-flit marker per requester
in_valid  input  N  flit valid per requester
in_ready  output  N  flit accepted per requester
out_flit  output  NOC_FLIT_WIDTH  merged flit to NoC
out_last  output  1  last flit of the current packet
out_valid  output  1  merged flit valid
out_ready  input  1  NoC accepts flit
grant  output  N  one-hot current owner; 0 when idle
busy  output  1  1 while a packet is locked

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, owner=0, rr_ptr=N-1 (requester 0 has highest priority first). Outputs: in_ready=0, out_valid=0, out_last=0, out_flit=0, grant=0, busy=0.
- State machine, two states:
  - IDLE: if any in_valid=1, select the first requester with valid set, searching i = rr_ptr+1, rr_ptr+2, ... modulo N. Register owner=i and go to LOCKED. No flit moves in this cycle. If no in_valid bit is set, stay in IDLE.
  - LOCKED: datapath is combinational from owner.
    - out_flit = in_flit[owner], out_last = in_last[owner], out_valid = in_valid[owner].
    - in_ready[owner] = out_ready; all other in_ready = 0.
    - A transfer occurs when out_valid and out_ready are both 1.
    - On a transfer with out_last=1: go to IDLE, rr_ptr=owner.
    - Otherwise stay in LOCKED.
- grant = one-hot(owner) and busy=1 in LOCKED only. In IDLE, out_flit, out_last and out_valid are forced to 0.
- Latency: 1 cycle of arbitration before the first flit of each packet. After a last flit, at least 1 IDLE cycle before the next grant. Per-packet overhead is exactly 1 cycle when requests are continuous.
- Fairness: the requester that just finished has lowest priority in the next arbitration, so no requester waits more than N-1 packets.
- Boundary conditions:
  - Single-flit packet (last on first flit): one transfer, then IDLE.
  - Owner drops in_valid mid-packet: stay LOCKED, out_valid=0 (bubble); other requesters stay blocked.
  - out_ready=0: out_flit and out_last hold the owner's inputs. Owner is responsible for holding stable data.
  - Owner's in_valid deasserts after the grant but before its first flit: stay LOCKED and wait.
  - Simultaneous requests: resolved only by rr_ptr order.
  - N=1: degenerates to a pass-through with one IDLE cycle per packet.
  - Reset mid-packet: lock is dropped immediately and outputs go to their reset values. The partial packet is not completed; upstream and downstream are reset together.
- No flit storage: the block never drops or duplicates a flit. Flit count out equals the sum of flit counts in.

Test Plan:
- Reset then single request: N=4, requester 2 sends a 3-flit packet 0xA0,0xA1,0xA2 with out_ready=1 -> grant=4'b0100 from cycle 2, out_flit sequence A0,A1,A2, last on A2, then grant=0 and busy=0.
- Round-robin: all 4 requesters continuously send 2-flit packets -> grant order 0,1,2,3,0, one IDLE cycle between packets, no interleaving.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-flit packet from requester 1 -> in_ready[1] mirrors out_ready, out_flit is held while out_ready=0, all 4 flits are delivered in order.
- Owner bubble: requester 3 deasserts in_valid for 2 cycles mid-packet while requester 0 is valid -> out_valid=0 for those cycles, grant stays 4'b1000, requester 0 is granted only after requester 3's last flit.
- Single-flit packets: requesters 0 and 1 each send 1-flit packets back to back -> alternating grants, each packet takes 2 cycles (arbitrate plus transfer).
- Async reset mid-packet: assert rst=0 between clock edges after the 2nd of 4 flits -> out_valid, in_ready and grant become 0 immediately; after release, requester 0 wins first.
